fb_fill: RTL and testbench

FB_FILL -- requirements
Module: fb_fill

---
 rtl/fb_fill.sv | 144 ++++++++++++++
 tb/tb_fb_fill.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_fill.sv
// Rectangle fill engine: clips a command to the framebuffer and streams
// one masked 32-bit word write per cycle, row by row, with no gaps.
module fb_fill #(
  parameter int          H_RES     = 320,
  parameter int          V_RES     = 240,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [9:0]  cmd_h,
  input  logic [7:0]  cmd_color,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_we
);
  localparam int          NUM_LANES = 4;
  localparam logic [10:0] H_END     = 11'(H_RES);
  localparam logic [10:0] V_END     = 11'(V_RES);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;
  state_t state, state_nxt;

  logic [9:0]  x_q, y_q, w_q, h_q;
  logic [7:0]  color_q;
  logic [10:0] x_end, y_end, cur_x, cur_y;
  logic [31:0] row_base;
  logic        done_q, done_set;

  logic [10:0] x_sum, y_sum;
  logic        empty;
  logic [11:0] word_next;
  logic        row_last, cmd_last;
  logic [NUM_LANES-1:0] lane_en;

  assign x_sum = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum = {1'b0, y_q} + {1'b0, h_q};
  assign empty = (w_q == '0) || (h_q == '0) ||
                 ({1'b0, x_q} >= H_END) || ({1'b0, y_q} >= V_END);

  // row_base is word aligned, so word boundaries follow cur_x alone
  assign word_next = {1'b0, cur_x[10:2], 2'b00} + 12'd4;
  assign row_last  = word_next >= {1'b0, x_end};
  assign cmd_last  = row_last && (cur_y == y_end - 11'd1);

  generate
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      logic [10:0] lane_x;
      assign lane_x     = {cur_x[10:2], 2'(k)};
      assign lane_en[k] = (cur_x[1:0] <= 2'(k)) && (lane_x < x_end);
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      IDLE:  if (cmd_valid) state_nxt = SETUP;
      SETUP: begin
        if (empty) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end else begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (cmd_last) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      x_end    <= '0;
      y_end    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      row_base <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_set;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
          end
        end
        SETUP: begin
          x_end    <= (x_sum > H_END) ? H_END : x_sum;
          y_end    <= (y_sum > V_END) ? V_END : y_sum;
          cur_x    <= {1'b0, x_q};
          cur_y    <= {1'b0, y_q};
          row_base <= BASE_ADDR + 32'(y_q) * 32'(H_RES);
        end
        WRITE: begin
          // per-row advance is an add, keeping multipliers out of the loop
          if (row_last) begin
            cur_x    <= {1'b0, x_q};
            cur_y    <= cur_y + 11'd1;
            row_base <= row_base + 32'(H_RES);
          end else begin
            cur_x <= word_next[10:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign done      = done_q;
  assign mem_we    = (state == WRITE);
  assign mem_wmask = mem_we ? lane_en : '0;
  assign mem_addr  = mem_we ? row_base + {21'd0, cur_x[10:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? {4{color_q}} : '0;

endmodule

// File: tb/tb_fb_fill.sv
// Bench for fb_fill: pixel-level model feeds a write scoreboard; table of
// commands plus hand sequences for reset abort and back-to-back accept.
module tb_fb_fill;
  localparam int H = 320;
  localparam int V = 240;
  localparam logic [31:0] BASE = 32'h0;
  localparam int BOUND = 25000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready, busy, done, mem_we;
  logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  fb_fill #(.H_RES(H), .V_RES(V), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int         x, y, w, h;
    logic [7:0] c;
    int         nwr;
  } vec_t;

  wr_t exp_q[$];
  int  wr_cycs[$];
  int  done_cycs[$];
  int  rdy_done[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: scoreboard compare of every write, idle-mask check, done log
  always @(negedge clk) begin
    if (resetn) begin
      if (mem_we) begin
        tests++;
        wr_cycs.push_back(cyc);
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write cyc=%0d addr=%h mask=%b", cyc, mem_addr, mem_wmask);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_wmask !== e.mask || mem_wdata !== e.data ||
              cmd_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL write cyc=%0d got addr=%h mask=%b data=%h rdy=%b busy=%b exp addr=%h mask=%b data=%h rdy=0 busy=1",
                     cyc, mem_addr, mem_wmask, mem_wdata, cmd_ready, busy, e.addr, e.mask, e.data);
          end
        end
      end else if (mem_wmask !== 4'b0) begin
        tests++;
        fails++;
        $display("FAIL idle_mask cyc=%0d got %b exp 0000", cyc, mem_wmask);
      end
      if (done) begin
        done_cycs.push_back(cyc);
        rdy_done.push_back(int'(cmd_ready));
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  // pixel-by-pixel model, grouping touched pixels into words
  task automatic push_model(input vec_t v);
    int xe, ye;
    logic [31:0] a, wa, cur_wa;
    logic [3:0]  m;
    bit have;
    xe = (v.x + v.w > H) ? H : v.x + v.w;
    ye = (v.y + v.h > V) ? V : v.y + v.h;
    have = 0; m = '0; cur_wa = '0;
    for (int r = v.y; r < ye; r++)
      for (int p = v.x; p < xe; p++) begin
        a  = BASE + 32'(r * H + p);
        wa = {a[31:2], 2'b00};
        if (!have || wa != cur_wa) begin
          if (have) exp_q.push_back('{cur_wa, m, {4{v.c}}});
          have = 1; cur_wa = wa; m = '0;
        end
        m[a[1:0]] = 1'b1;
      end
    if (have) exp_q.push_back('{cur_wa, m, {4{v.c}}});
  endtask

  task automatic clear_logs();
    wr_cycs.delete();
    done_cycs.delete();
    rdy_done.delete();
  endtask

  task automatic drive(input vec_t v);
    cmd_x = 10'(v.x); cmd_y = 10'(v.y); cmd_w = 10'(v.w); cmd_h = 10'(v.h);
    cmd_color = v.c;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_done(input int n, input string name);
    int k;
    k = 0;
    while (done_cycs.size() < n && k < BOUND) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_cycs.size() < n) check({name, "_timeout"}, done_cycs.size(), n);
  endtask

  task automatic run_cmd(input vec_t v, input bit use_model, input string name);
    int acc;
    clear_logs();
    if (use_model) push_model(v);
    @(posedge clk); #1;
    check({name, "_ready_idle"}, int'(cmd_ready), 1);
    drive(v);
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done(1, name);
    @(posedge clk); #1;
    check({name, "_wr_count"}, wr_cycs.size(), v.nwr);
    check({name, "_sb_left"}, exp_q.size(), 0);
    check({name, "_done_count"}, done_cycs.size(), 1);
    if (done_cycs.size() > 0) check({name, "_ready_at_done"}, rdy_done[0], 1);
    if (v.nwr == 0 && done_cycs.size() > 0)
      check({name, "_done_lat"}, done_cycs[0] - acc, 2);
    if (v.nwr > 0 && wr_cycs.size() > 0) begin
      check({name, "_first_lat"}, wr_cycs[0] - acc, 2);
      check({name, "_contig"}, wr_cycs[wr_cycs.size()-1] - wr_cycs[0] + 1, v.nwr);
      if (done_cycs.size() > 0)
        check({name, "_done_after_last"}, done_cycs[0] - wr_cycs[wr_cycs.size()-1], 1);
    end
    exp_q.delete();
  endtask

  vec_t tbl[13];
  vec_t va, vb;
  int   acc, dcyc, k;

  initial begin
    tbl[0]  = '{2,   1,   7,   1,    8'hA5, 3};
    tbl[1]  = '{318, 239, 10,  5,    8'h3C, 1};
    tbl[2]  = '{10,  10,  0,   5,    8'h11, 0};
    tbl[3]  = '{10,  10,  5,   0,    8'h22, 0};
    tbl[4]  = '{320, 0,   4,   4,    8'h33, 0};
    tbl[5]  = '{0,   240, 4,   4,    8'h44, 0};
    tbl[6]  = '{1,   2,   2,   3,    8'h55, 3};
    tbl[7]  = '{3,   10,  6,   2,    8'h66, 6};
    tbl[8]  = '{316, 0,   8,   2,    8'h77, 2};
    tbl[9]  = '{5,   7,   1,   1,    8'h88, 1};
    tbl[10] = '{1020, 0,  3,   1,    8'h99, 0};
    tbl[11] = '{0,   239, 4,   1023, 8'hC3, 1};
    tbl[12] = '{0,   0,   320, 240,  8'hFF, 19200};

    // reset state, asynchronously forced
    #3;
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_mask", int'(mem_wmask), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // hand-computed expectations for the basic 7-pixel span
    exp_q.push_back('{32'h140, 4'b1100, 32'hA5A5A5A5});
    exp_q.push_back('{32'h144, 4'b1111, 32'hA5A5A5A5});
    exp_q.push_back('{32'h148, 4'b0001, 32'hA5A5A5A5});
    run_cmd(tbl[0], 1'b0, "hand_span");
    exp_q.delete();
    exp_q.push_back('{32'd76796, 4'b1100, 32'h3C3C3C3C});
    run_cmd(tbl[1], 1'b0, "hand_clip");

    for (int i = 0; i < 13; i++) run_cmd(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // reset during the second write abandons the command
    clear_logs();
    push_model(tbl[0]);
    @(posedge clk); #1;
    drive(tbl[0]);
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (cyc < acc + 3) begin @(posedge clk); #1; end
    check("abort_we_before", int'(mem_we), 1);
    check("abort_consumed", exp_q.size(), 2);
    resetn = 1'b0;
    #1;
    check("abort_we_async", int'(mem_we), 0);
    check("abort_mask_async", int'(mem_wmask), 0);
    check("abort_addr_async", int'(mem_addr), 0);
    check("abort_ready_async", int'(cmd_ready), 1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    exp_q.delete();
    clear_logs();
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_writes", wr_cycs.size(), 0);
    check("abort_no_done", done_cycs.size(), 0);
    check("abort_ready", int'(cmd_ready), 1);

    // cmd_valid held across two commands
    va = tbl[0];
    vb = '{0, 0, 4, 1, 8'h5A, 1};
    clear_logs();
    push_model(va);
    push_model(vb);
    @(posedge clk); #1;
    drive(va);
    dcyc = -1;
    k = 0;
    while (dcyc < 0 && k < BOUND) begin
      @(posedge clk); #1;
      k++;
      if (done) begin
        drive(vb);
        dcyc = cyc;
      end
    end
    if (dcyc < 0) check("b2b_first_done_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done(2, "b2b");
    @(posedge clk); #1;
    check("b2b_writes", wr_cycs.size(), 4);
    check("b2b_done_count", done_cycs.size(), 2);
    check("b2b_sb_left", exp_q.size(), 0);
    if (wr_cycs.size() == 4 && dcyc >= 0)
      check("b2b_second_lat", wr_cycs[3] - dcyc, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
